pipe_stage_reg: RTL and testbench

//   Generic inter-stage pipeline register for the pipelined CPU (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: 1-cycle latency, valid/ready stall, sync flush, optional skid slot.
// Backpressure: SKID=1 gives a registered-state in_ready (two entries); SKID=0 gives a combinational in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  // Control is forced to zero on an empty slot so a bubble never carries a write-enable.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state != TWO) & ~flush & ~clr;
    end else begin : g_single
      assign in_ready = (~out_valid | out_ready) & ~flush & ~clr;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= EMPTY;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      // Counters look at the outputs as they stood before this edge, flush or not.
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;

      if (flush) begin
        state     <= EMPTY;
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state     <= ONE;
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_ctrl <= in_ctrl;
              main_data <= in_data;
            end else if (in_fire) begin
              state     <= TWO;
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
            end else if (out_fire) begin
              state     <= EMPTY;
              main_ctrl <= '0;
            end
          end
          TWO: begin
            if (out_fire) begin
              state     <= ONE;
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
              skid_ctrl <= '0;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance, single-entry instance and a 4-bit-counter instance.
module tb_pipe_stage_reg;

  logic        clk;
  logic        clr;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ctrl;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  logic        n_flush;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [15:0] n_in_ctrl;
  logic [31:0] n_in_data;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_out_ctrl;
  logic [31:0] n_out_data;
  logic [15:0] n_stall_cnt;
  logic [15:0] n_bubble_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_ctrl;
  logic [31:0] s_out_data;
  logic [3:0]  s_stall_cnt;
  logic [3:0]  s_bubble_cnt;

  int n_cmp;
  int n_err;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .clr(clr), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_ctrl(n_in_ctrl), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
    .stall_cnt(n_stall_cnt), .bubble_cnt(n_bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required one");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [31:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 16'hFFFF;
    in_data = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    n_flush = 1'b0;
    n_in_valid = 1'b1;
    n_in_ctrl = 16'hFFFF;
    n_in_data = 32'hDEAD_BEEF;
    n_out_ready = 1'b0;

    // T1 reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_out_valid", 32'(out_valid), 32'd0);
      check("t1_in_ready", 32'(in_ready), 32'd0);
    end
    check("t1_out_ctrl", 32'(out_ctrl), 32'd0);
    check("t1_out_data", out_data, 32'd0);
    check("t1_stall", 32'(stall_cnt), 32'd0);
    check("t1_bubble", 32'(bubble_cnt), 32'd0);
    check("t1_single_in_ready", 32'(n_in_ready), 32'd0);
    clr = 1'b0;
    in_valid = 1'b0;
    n_in_valid = 1'b0;
    #1;
    check("t1_in_ready_after", 32'(in_ready), 32'd1);
    check("t1_out_valid_after", 32'(out_valid), 32'd0);
    check("t1_out_data_after", out_data, 32'd0);

    // T6 saturation while empty
    for (int i = 0; i < 10; i++) tick();
    check("t6_sat_bubble_10", 32'(s_bubble_cnt), 32'd10);
    for (int i = 0; i < 10; i++) tick();
    check("t6_sat_bubble_20", 32'(s_bubble_cnt), 32'd15);
    check("t6_wide_bubble_20", 32'(bubble_cnt), 32'd20);
    for (int i = 0; i < 5; i++) tick();
    check("t6_sat_bubble_hold", 32'(s_bubble_cnt), 32'd15);
    check("t6_wide_bubble_25", 32'(bubble_cnt), 32'd25);

    // T2 streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(16'(i), 32'(i));
      #1;
      check("t2_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("t2_out_valid", 32'(out_valid), 32'd1);
      check("t2_out_data", out_data, 32'(i));
      check("t2_out_ctrl", 32'(out_ctrl), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("t2_drain_valid", 32'(out_valid), 32'd0);
    check("t2_drain_ctrl", 32'(out_ctrl), 32'd0);
    check("t2_drain_data_hold", out_data, 32'd8);
    check("t2_stall", 32'(stall_cnt), 32'd0);
    check("t2_bubble", 32'(bubble_cnt), 32'd26);

    // T3 stall into skid slot, then release
    out_ready = 1'b0;
    push(16'h0005, 32'd5);
    tick();
    check("t3_first", out_data, 32'd5);
    push(16'h0006, 32'd6);
    #1;
    check("t3_in_ready_one", 32'(in_ready), 32'd1);
    tick();
    push(16'h0007, 32'd7);
    #1;
    check("t3_in_ready_two", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("t3_held_data", out_data, 32'd5);
    check("t3_held_ctrl", 32'(out_ctrl), 32'h0005);
    check("t3_stall_held", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_release", 32'(in_ready), 32'd0);
    tick();
    check("t3_second", out_data, 32'd6);
    check("t3_in_ready_after", 32'(in_ready), 32'd1);
    tick();
    check("t3_third", out_data, 32'd7);
    check("t3_third_ctrl", 32'(out_ctrl), 32'h0007);
    in_valid = 1'b0;
    tick();
    check("t3_empty", 32'(out_valid), 32'd0);
    check("t3_stall_final", 32'(stall_cnt), 32'd3);

    // T4 flush from TWO
    out_ready = 1'b0;
    push(16'h00A5, 32'h100);
    tick();
    push(16'h005A, 32'h200);
    tick();
    check("t4_two_ctrl", 32'(out_ctrl), 32'h00A5);
    push(16'h0033, 32'h300);
    flush = 1'b1;
    #1;
    check("t4_in_ready_flush", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("t4_valid_after", 32'(out_valid), 32'd0);
    check("t4_ctrl_after", 32'(out_ctrl), 32'd0);
    check("t4_data_hold", out_data, 32'h100);
    check("t4_stall", 32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    push(16'h0077, 32'h400);
    tick();
    check("t4_refill_ctrl", 32'(out_ctrl), 32'h0077);
    check("t4_refill_data", out_data, 32'h400);
    in_valid = 1'b0;
    tick();
    check("t4_refill_drain", 32'(out_valid), 32'd0);

    // T5 single-entry mode
    n_in_valid = 1'b1;
    n_in_ctrl = 16'h0011;
    n_in_data = 32'h11;
    #1;
    check("t5_in_ready_empty", 32'(n_in_ready), 32'd1);
    tick();
    n_in_ctrl = 16'h0022;
    n_in_data = 32'h22;
    #1;
    check("t5_in_ready_full", 32'(n_in_ready), 32'd0);
    tick();
    check("t5_held", n_out_data, 32'h11);
    n_out_ready = 1'b1;
    #1;
    check("t5_in_ready_same_cycle", 32'(n_in_ready), 32'd1);
    tick();
    check("t5_b2b_1", n_out_data, 32'h22);
    check("t5_b2b_1_ctrl", 32'(n_out_ctrl), 32'h0022);
    n_in_ctrl = 16'h0033;
    n_in_data = 32'h33;
    tick();
    check("t5_b2b_2", n_out_data, 32'h33);
    n_in_valid = 1'b0;
    tick();
    check("t5_empty", 32'(n_out_valid), 32'd0);
    check("t5_stall", 32'(n_stall_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
